// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states
//   CNT_W       : width of the beat and idle counters
//   owner_w()   : width of an owner/requester index for a given requester count
package fifo_arb_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Index width for nreq requesters; never narrower than one bit.
  function automatic int unsigned owner_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder: selects the first requester at or after last+1
// (mod NREQ) whose request bit is set.
//   req   in  NREQ  request vector
//   last  in  IW    index of the previous owner
//   valid out 1     at least one request bit set
//   idx   out IW    selected requester index (0 when valid is low)
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down to last+1 so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      cand = IW'((32'(last) + k) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the single write port of one FIFO between
// NREQ producers. Ownership is held for a burst that ends on a word flagged
// last, on reaching MAX_BURST accepted words, or after IDLE_TIMEOUT cycles in
// which the owner has no word. Accepted words go straight into the FIFO,
// gated by fifo_full.
//
// Optional feature: define FIFO_ARB_PRIO_EN to give requester 0 strict
// priority at arbitration; requesters 1..NREQ-1 then rotate among themselves.
//
// Ports:
//   clk           in   1            clock, rising edge
//   res           in   1            synchronous active-high reset
//   req           in   NREQ         requester i has a valid word
//   req_data      in   NREQ*DWIDTH  packed words, slice i per requester
//   req_last      in   NREQ         word on slice i ends its burst
//   gnt           out  NREQ         one-hot accept strobe (combinational)
//   fifo_full     in   1            FIFO full flag
//   fifo_shiftin  out  1            FIFO write strobe (combinational)
//   fifo_data_in  out  DWIDTH       FIFO write data (combinational)
//   owner         out  clog2(NREQ)  current or last owner index
//   busy          out  1            high while a burst is owned
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          gnt,
  input  logic                     fifo_full,
  output logic                     fifo_shiftin,
  output logic [DWIDTH-1:0]        fifo_data_in,
  output logic [owner_w(NREQ)-1:0] owner,
  output logic                     busy
);

  localparam int unsigned IW = owner_w(NREQ);
  localparam logic [CNT_W-1:0] MAX_B   = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] IDLE_TO = CNT_W'(IDLE_TIMEOUT);
  localparam logic [IW-1:0]    LAST_RST = IW'(NREQ - 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q,  last_d;
  logic [CNT_W-1:0] beat_q,  beat_d;
  logic [CNT_W-1:0] idle_q,  idle_d;

  logic [NREQ-1:0]   rr_req;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              arb_valid;
  logic [IW-1:0]     arb_idx;

  logic              own_req;
  logic              own_last;
  logic [DWIDTH-1:0] own_data;
  logic              accept;
  logic              release_c;

  // Arbitration candidate selection.
`ifdef FIFO_ARB_PRIO_EN
  assign rr_req = req & ~NREQ'(1);

  always_comb begin
    arb_valid = pick_valid;
    arb_idx   = pick_idx;
    if (req[0]) begin
      arb_valid = 1'b1;
      arb_idx   = '0;
    end
  end
`else
  assign rr_req    = req;
  assign arb_valid = pick_valid;
  assign arb_idx   = pick_idx;
`endif

  fifo_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (rr_req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Current owner's request, last flag and word.
  assign own_req  = req[owner_q];
  assign own_last = req_last[owner_q];
  assign own_data = req_data[32'(owner_q) * DWIDTH +: DWIDTH];

  // A full FIFO stalls the grant but is not an idle cycle.
  assign accept = (state_q == ARB_BURST) && own_req && !fifo_full;

  // Next state, counters and write-port drive.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    beat_d       = beat_q;
    idle_d       = idle_q;
    gnt          = '0;
    fifo_data_in = '0;
    release_c    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          beat_d  = '0;
          idle_d  = '0;
          state_d = ARB_BURST;
        end
      end

      ARB_BURST: begin
        fifo_data_in = own_data;
        if (accept) begin
          gnt[owner_q] = 1'b1;
          idle_d       = '0;
          if (beat_q < MAX_B) begin
            beat_d = beat_q + CNT_W'(1);
          end
          // This accept ends the burst if flagged last or it is the MAX_BURST-th word.
          if (own_last || (beat_q >= MAX_B - CNT_W'(1))) begin
            release_c = 1'b1;
          end
        end else if (!own_req) begin
          if (idle_q < IDLE_TO) begin
            idle_d = idle_q + CNT_W'(1);
          end
          if (idle_q >= IDLE_TO - CNT_W'(1)) begin
            release_c = 1'b1;
          end
        end

        if (release_c) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign fifo_shiftin = |gnt;
  assign owner        = owner_q;
  assign busy         = (state_q == ARB_BURST);

  // State and counter registers; reset makes requester 0 win first.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter that shares the single write port (`shiftin`/`data_in`) of one `fifo` instance between `NREQ` producers. It sits directly in front of the FIFO and decides which producer owns the write port. Ownership is held for a burst. Every accepted word is pushed into the FIFO in the same cycle, gated by the FIFO's `full`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..16)
- `DWIDTH`, 32, data word width; matches the FIFO's `DWIDTH`
- `MAX_BURST`, 4, maximum words per ownership (1..255)
- `IDLE_TIMEOUT`, 8, consecutive owner-idle cycles before forced release (1..255)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `res`  in  1  reset, synchronous, active-high
- `req`  in  NREQ  requester i has a valid word
- `req_data`  in  NREQ*DWIDTH  packed words; slice i = `req_data[i*DWIDTH +: DWIDTH]`
- `req_last`  in  NREQ  word on slice i ends its burst
- `gnt`  out  NREQ  one-hot or zero; word i accepted this cycle (requester pops)
- `fifo_full`  in  1  FIFO `full`
- `fifo_shiftin`  out  1  to FIFO `shiftin`
- `fifo_data_in`  out  DWIDTH  to FIFO `data_in`
- `owner`  out  $clog2(NREQ)  current or last owner index
- `busy`  out  1  high in BURST state

## Operation
FSM states are IDLE and BURST.

- **IDLE**
  - `gnt`=0.
  - If any `req` bit is set: pick the first requester at or after `last+1` (mod NREQ) with `req` high.
  - Latch it into `owner`, clear the beat and idle counters, go to BURST.
  - `fifo_full` does not block arbitration.
- **BURST**
  - `gnt[owner] = req[owner] & ~fifo_full`. All other `gnt` bits are 0.
  - Accept occurs on a cycle with `gnt[owner]`=1.
  - On each accept, increment the beat counter and clear the idle counter.
  - On each cycle with `req[owner]`=0, increment the idle counter. Cycles where `req[owner]`=1 but `fifo_full` blocks the grant do not count as idle.
  - Exit to IDLE at the clock edge after any of:
    - an accept with `req_last[owner]`=1;
    - an accept that brings the beat count to `MAX_BURST`;
    - the idle count reaching `IDLE_TIMEOUT`.
  - On exit, `last <= owner`.
- **Outputs** (combinational from state and inputs):
  - `fifo_shiftin = |gnt`
  - `fifo_data_in` = the owner's slice while in BURST, else 0.
- **Guarantee:** `fifo_shiftin` is never high while `fifo_full`=1, so no overflow. Every producer with `req` held is granted within NREQ arbitrations.
- **Width rules:**
  - The beat counter is 8 bits and saturates at `MAX_BURST`.
  - The idle counter is 8 bits and saturates at `IDLE_TIMEOUT`.
  - `last` wraps from NREQ-1 to 0.

## Timing
- **Reset values:** state=IDLE, `last`=NREQ-1 (requester 0 wins first), `owner`=0, counters=0, `gnt`=0, `fifo_shiftin`=0, `fifo_data_in`=0, `busy`=0.
- **Latency:**
  - One arbitration cycle in IDLE, then the first grant can come in the next cycle.
  - Back-to-back bursts therefore have a one-cycle gap.
  - Sustained throughput within a burst is 1 word/cycle.
- **Handshake:** a requester keeps `req`/data/`last` stable until it sees `gnt`. It may change them in the cycle after `gnt`.
- **`fifo_full` mid-burst:** grants stall, the burst stays owned and no idle counting occurs. Grants resume in the cycle `fifo_full` drops.
- **Reset mid-burst:** return to IDLE on the next edge. The partial burst is abandoned and the FIFO contents are untouched.
- **`req[owner]` drop:** dropping `req[owner]` without `last` holds ownership until the timeout.

## Configuration
- `FIFO_ARB_PRIO_EN` defined: requester 0 has strict priority in IDLE arbitration. If `req[0]`=1, it wins regardless of `last`. Requesters 1..NREQ-1 rotate round-robin among themselves. Burst limits still apply to requester 0.
- Undefined: pure round-robin over all NREQ requesters.

## Structure
- Package `fifo_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_BURST};
  - localparam `CNT_W`=8;
  - function for the owner width, `$clog2(NREQ)`.
- Sub-module `fifo_arb_rr_pick`:
  - combinational rotating priority encoder;
  - inputs `req` and `last`, outputs `valid` and `idx`.
  - The priority override from `FIFO_ARB_PRIO_EN` is applied in the parent.

## Test plan
All scenarios use NREQ=4, DWIDTH=32, MAX_BURST=4, IDLE_TIMEOUT=8, with a `fifo` of AWIDTH=3 attached.

1. **Reset:** hold `res`=1 for 3 cycles with `req`=4'b1111 → `gnt`=0, `fifo_shiftin`=0, `busy`=0, `owner`=0.
2. **Round-robin:** all four requesters request, each with a 2-word burst (`last` on word 2) → grant order 0,1,2,3,0. Each burst is 2 consecutive grant cycles, separated by one idle cycle.
3. **MAX_BURST cap:** requester 2 alone, streaming 10 words without `last` → 4 grants, release, re-arbitration back to 2. Bursts are 4,4,2 once `last` is set on word 10. The FIFO holds the words in order (checked after drain).
4. **Full backpressure:** requester 1 pushes 10 words into the empty 8-deep FIFO → exactly 8 grants. `gnt`=0 while `full`=1, with no timeout release. After 2 FIFO reads, the remaining 2 words are granted.
5. **Idle timeout:** requester 3 sends 1 word without `last`, then drops `req` → release after 8 idle cycles. A pending requester 0 is granted 2 cycles later.
6. **Priority (`FIFO_ARB_PRIO_EN` defined):** `req`=4'b1110 with `last`=2, then `req[0]` rises → requester 0 wins the next arbitration ahead of 3. Without the macro, 3 wins.
